// File: rtl/led_frame_scanner.sv
// led_frame_scanner: reader side of the 8x8 pipe-frame interface.
// Takes the red[7:0][7:0] frame from the generator and drives an LED
// matrix one row at a time. The frame is double-buffered, so an update
// that arrives mid-scan never tears the picture.
// Optional macro SCAN_BLANK_EN inserts BLANK_CYCLES all-off cycles
// between rows to suppress ghosting. The default build has no blanking.
module led_frame_scanner #(
  parameter int DWELL        = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0][7:0] red,
  input  logic            load,
  output logic [7:0]      row_out,
  output logic [7:0]      col_out,
  output logic            frame_done,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
  localparam logic [7:0]  BLANK_LAST = 8'(BLANK_CYCLES - 1);

  state_t          state;
  logic [7:0][7:0] shadow;
  logic [7:0][7:0] pending;
  logic            pend_v;
  logic [2:0]      row_idx;
  logic [15:0]     dwell_cnt;
  logic [7:0]      blank_cnt;

  logic row_end;
  logic frame_end;

  // The end of a row's dwell and the frame boundary (row 7, last dwell
  // cycle) are decoded from registered state only.
  always_comb begin
    row_end   = (state == DRIVE) && (dwell_cnt == DWELL_LAST);
    frame_end = row_end && (row_idx == 3'd7);
  end

  // Output decode: rows and columns are lit only while driving. Nothing
  // here depends on red or load, so no combinational path reaches the pins.
  always_comb begin
    row_out    = 8'h00;
    col_out    = 8'h00;
    frame_done = frame_end;
    busy       = (state != IDLE);
    if (state == DRIVE) begin
      row_out = 8'b1 << row_idx;
      col_out = shadow[row_idx];
    end
  end

  // Scan state machine plus frame buffering. When a load lands on the
  // boundary cycle, red goes straight into shadow and discards any staged
  // frame, because it is newer than anything waiting in pending.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shadow    <= '0;
      pending   <= '0;
      pend_v    <= 1'b0;
      row_idx   <= 3'd0;
      dwell_cnt <= 16'd0;
      blank_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shadow    <= red;
            row_idx   <= 3'd0;
            dwell_cnt <= 16'd0;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          if (row_end) begin
            dwell_cnt <= 16'd0;
            row_idx   <= row_idx + 3'd1;
`ifdef SCAN_BLANK_EN
            blank_cnt <= 8'd0;
            state     <= BLANK;
`endif
          end else begin
            dwell_cnt <= dwell_cnt + 16'd1;
          end
        end
        BLANK: begin
          if (blank_cnt == BLANK_LAST) begin
            blank_cnt <= 8'd0;
            state     <= DRIVE;
          end else begin
            blank_cnt <= blank_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (state != IDLE) begin
        if (frame_end && load) begin
          shadow <= red;
          pend_v <= 1'b0;
        end else if (frame_end && pend_v) begin
          shadow <= pending;
          pend_v <= 1'b0;
        end else if (load) begin
          pending <= red;
          pend_v  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_frame_scanner.sv
// tb_led_frame_scanner: directed bench for led_frame_scanner with
// DWELL=4 and BLANK_CYCLES=2. Blank cycles are expected only when
// SCAN_BLANK_EN is defined.
module tb_led_frame_scanner;

  localparam int DWELL = 4;
  localparam int BLANK = 2;
`ifdef SCAN_BLANK_EN
  localparam int GAP = BLANK;
`else
  localparam int GAP = 0;
`endif

  logic            clock;
  logic            reset;
  logic [7:0][7:0] red;
  logic            load;
  logic [7:0]      row_out;
  logic [7:0]      col_out;
  logic            frame_done;
  logic            busy;

  int errors = 0;
  int checks = 0;

  led_frame_scanner #(.DWELL(DWELL), .BLANK_CYCLES(BLANK)) dut (
    .clock(clock), .reset(reset), .red(red), .load(load),
    .row_out(row_out), .col_out(col_out),
    .frame_done(frame_done), .busy(busy)
  );

  // Free-running clock with a 10-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advances one clock and settles just after the edge, away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, " row_out"}, row_out, 8'h00);
    check_output({tag, " col_out"}, col_out, 8'h00);
    check_output({tag, " busy"}, {7'd0, busy}, 8'h00);
    check_output({tag, " frame_done"}, {7'd0, frame_done}, 8'h00);
  endtask

  // Walks one whole frame starting at row 0, dwell 0, and checks every
  // cycle. Up to two loads can be injected at drive-cycle indices
  // (row*DWELL + dwell); -1 disables a load.
  task automatic run_frame(input string tag, input logic [7:0][7:0] exp,
                           input int at_a, input logic [7:0][7:0] dat_a,
                           input int at_b, input logic [7:0][7:0] dat_b);
    for (int r = 0; r < 8; r++) begin
      for (int d = 0; d < DWELL; d++) begin
        check_output($sformatf("%s r%0d d%0d row", tag, r, d), row_out, 8'(1 << r));
        check_output($sformatf("%s r%0d d%0d col", tag, r, d), col_out, exp[r]);
        check_output($sformatf("%s r%0d d%0d done", tag, r, d), {7'd0, frame_done},
                     {7'd0, (r == 7) && (d == DWELL - 1)});
        if (r * DWELL + d == at_a) begin red = dat_a; load = 1'b1; end
        if (r * DWELL + d == at_b) begin red = dat_b; load = 1'b1; end
        step();
        load = 1'b0;
        red  = {8{8'h5A}};
      end
      for (int b = 0; b < GAP; b++) begin
        check_output($sformatf("%s r%0d blank%0d row", tag, r, b), row_out, 8'h00);
        check_output($sformatf("%s r%0d blank%0d col", tag, r, b), col_out, 8'h00);
        step();
      end
    end
  endtask

  // Linear sequence of directed steps.
  initial begin
    logic [7:0][7:0] fa, fb, fb2, fc, fd, fe, fff;
    for (int r = 0; r < 8; r++) begin
      fa[r] = 8'(8'h01 << r);
      fd[r] = 8'(8'h80 >> r);
      fb[r] = 8'hFF;
      fb2[r] = 8'h3C;
      fc[r] = 8'hAA;
      fe[r] = 8'h66;
    end
    fff = fb;

    reset = 1'b1;
    load  = 1'b0;
    red   = '0;
    step();
    step();
    reset = 1'b0;
    check_idle("reset");

    // Idle with no load: nothing lights and frame_done stays low.
    for (int i = 0; i < 10; i++) begin
      step();
      check_idle($sformatf("idle%0d", i));
    end

    // First frame A: row 0 shows one cycle after the load edge.
    red  = fa;
    load = 1'b1;
    step();
    load = 1'b0;
    red  = '0;
    check_output("busy after load", {7'd0, busy}, 8'h01);
    run_frame("A1", fa, -1, fa, -1, fa);

    // Load B during row 3: A stays until the frame boundary.
    run_frame("A2", fa, 3 * DWELL, fff, -1, fa);
    run_frame("B", fff, -1, fa, -1, fa);

    // Load B2 then C within one frame: the latest load wins.
    run_frame("B again", fff, 2 * DWELL + 1, fb2, 5 * DWELL, fc);
    run_frame("C", fc, -1, fa, -1, fa);

    // Stage E, then load D on the boundary cycle: D bypasses and E is dropped.
    run_frame("C again", fc, 10, fe, 8 * DWELL - 1, fd);
    run_frame("D", fd, -1, fa, -1, fa);
    run_frame("D again", fd, -1, fa, -1, fa);

    // Reset in the middle of row 5.
    for (int i = 0; i < 5 * (DWELL + GAP) + 1; i++) step();
    check_output("mid row5 row", row_out, 8'h20);
    check_output("mid row5 col", col_out, fd[5]);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("mid reset");
    step();
    check_idle("after reset");

    // A later load restarts from row 0 with the new frame.
    red  = fb2;
    load = 1'b1;
    step();
    load = 1'b0;
    red  = '0;
    run_frame("restart", fb2, -1, fa, -1, fa);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_frame_scanner.md
Name: led_frame_scanner

Overview:
- Reader side of the 8x8 pipe-frame interface: consumes the red[7:0][7:0] frame built by the pipe/frame generator and drives the physical LED matrix one row at a time.
- Double-buffers the frame so a mid-scan update never tears.
- Scans rows 0..7 with a programmable dwell.
- Reports frame completion so upstream can pace scroll and update logic.

Parameters:
- DWELL, 16: clock cycles each row is driven; legal range 2..65535.
- BLANK_CYCLES, 2: all-off cycles between rows; used only when SCAN_BLANK_EN is defined; legal range 1..255.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- red  in  [7:0][7:0]  frame from the generator; red[r] is the column bit pattern of row r
- load  in  1  one-cycle strobe; capture red on this edge
- row_out  out  8  one-hot active-high row select; all zero when not driving
- col_out  out  8  column data for the selected row; zero when row_out is zero
- frame_done  out  1  one-cycle pulse when row 7 finishes its dwell
- busy  out  1  high while scanning, i.e. state is not IDLE

Behaviour:
- Registers:
  - shadow[7:0][7:0]: frame being displayed
  - pending[7:0][7:0] and pend_v: staged frame and its valid flag
  - row_idx: 3 bits
  - dwell_cnt: 16 bits
  - state: IDLE, DRIVE, BLANK
- Reset (synchronous, overrides everything, including mid-scan):
  - state=IDLE; shadow, pending, pend_v, row_idx, dwell_cnt cleared.
  - row_out=0, col_out=0, frame_done=0, busy=0 on the cycle after the reset edge.
- Outputs:
  - row_out = (state==DRIVE) ? (8'b1 << row_idx) : 0
  - col_out = (state==DRIVE) ? shadow[row_idx] : 0
  - Both decode combinationally from registered state only; no combinational path from red or load.
- IDLE:
  - On load: shadow<=red, row_idx<=0, dwell_cnt<=0, state<=DRIVE.
  - Row 0 appears the cycle after the load edge (1-cycle latency).
- DRIVE:
  - dwell_cnt increments each cycle.
  - At dwell_cnt==DWELL-1: dwell_cnt<=0, then advance:
    - row_idx<7: row_idx<=row_idx+1, stay in DRIVE (BLANK when the macro is on).
    - row_idx==7: frame_done asserted the same cycle; row_idx<=0. If pend_v: shadow<=pending, pend_v<=0. Scan continues indefinitely; there is no return to IDLE except by reset.
- load while scanning:
  - pending<=red, pend_v<=1.
  - A second load before the boundary overwrites pending; latest wins and no error is flagged.
- load on the boundary cycle (row 7, last dwell cycle):
  - red bypasses pending straight into shadow; pend_v<=0.
  - The new frame is shown from row 0 of the next frame.
- Each row is driven exactly DWELL cycles.
- Frame period: 8*DWELL cycles without the macro; 8*(DWELL+BLANK_CYCLES) with it.
- frame_done is registered-state decoded, high for exactly one cycle per frame, never in IDLE.
- row_idx wraps 7→0; dwell_cnt never exceeds DWELL-1.

Optional Feature:
- Macro: SCAN_BLANK_EN
- Defined:
  - After each row's dwell, state=BLANK for BLANK_CYCLES cycles with row_out=0 and col_out=0. This suppresses ghosting.
  - row_idx advances on entry to BLANK.
  - The frame boundary (frame_done, shadow swap) occurs on the last dwell cycle of row 7, before its blank.
  - BLANK→DRIVE when the blank counter reaches BLANK_CYCLES-1.
- Undefined:
  - No BLANK state; rows are back-to-back with zero gap.
  - BLANK_CYCLES is ignored.

Test Plan (bench uses DWELL=4, BLANK_CYCLES=2):
- Reset, then idle 10 cycles → row_out=0, col_out=0, busy=0, frame_done never high.
- red[r]=8'h01<<r, pulse load → next cycle row_out=8'h01 and col_out=8'h01 for 4 cycles; then row_out=8'h02 and col_out=8'h02; … row 7 col_out=8'h80. frame_done high on cycle 32 only (macro off).
- Scanning frame A; load frame B (all 8'hFF) during row 3 → rows 3..7 still show A; from the next row 0 col_out=8'hFF.
- Load B then C (8'hAA) within one frame → next frame shows 8'hAA on every row; B never appears.
- Load D on the exact row-7 last-dwell cycle → next frame shows D; pend_v=0 afterwards.
- Reset asserted mid-row 5 → outputs 0 and busy=0 on the next cycle. A later load restarts at row 0 with the new frame.
- With SCAN_BLANK_EN → 2 all-zero cycles between rows; frame period 48; frame_done on the last dwell cycle of row 7.
